// File: rtl/tick_scheduler_if.sv
// Config / control / status bundle for the four-channel tick scheduler.
interface tick_scheduler_if #(
    parameter int PW = 16
);
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          cfg_mode;
    logic          cfg_err;
    logic [3:0]    ch_start;
    logic [3:0]    ch_stop;
    logic [3:0]    irq_clr;
    logic          base_tick;
    logic [3:0]    tick;
    logic [3:0]    busy;
    logic [3:0]    pending;
    logic          irq;

    // Host side: drives config and strobes, observes status.
    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_mode, ch_start, ch_stop, irq_clr,
        input  cfg_err, base_tick, tick, busy, pending, irq
    );

    // Scheduler side.
    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_mode, ch_start, ch_stop, irq_clr,
        output cfg_err, base_tick, tick, busy, pending, irq
    );
endinterface

// File: rtl/tick_scheduler.sv
// Four-channel tick scheduler: one free-running prescaler produces base_tick,
// each channel counts base_ticks against its own period and emits tick pulses
// (periodic or one-shot). Sticky pending bits are ORed into a registered irq.
module tick_scheduler #(
    parameter int PRESCALE = 100_000,
    parameter int PW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    tick_scheduler_if.slave  bus
);
    localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_RUN   = 1'b1;

    logic [31:0] r_pcnt;
    logic        r_base_tick;
    logic        r_cfg_err;
    logic        r_irq;
    logic [3:0]  w_tick;
    logic [3:0]  w_busy;
    logic [3:0]  w_pending;
    logic        w_cfg_ok;

    // Free-running prescaler; base_tick is the registered terminal-count flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt      <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_base_tick <= (r_pcnt == PS_LAST);
            r_pcnt      <= (r_pcnt == PS_LAST) ? '0 : r_pcnt + 32'd1;
        end
    end

    // A write only lands on an idle channel that is not being started this cycle.
    assign w_cfg_ok = bus.cfg_we && !w_busy[bus.cfg_ch] && !bus.ch_start[bus.cfg_ch];

    // Rejected-write flag and irq summary, both registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we && !w_cfg_ok;
            r_irq     <= |w_pending;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [PW-1:0] r_period;
        logic          r_mode;
        logic [PW-1:0] r_cnt;
        logic [0:0]    r_state;
        logic          r_tick;
        logic          r_pend;
        logic          w_we;
        logic          w_expire;

        assign w_we     = w_cfg_ok && (bus.cfg_ch == 2'(g));
        // Restart and stop both override an expiry landing in the same cycle.
        assign w_expire = (r_state == S_RUN) && !bus.ch_stop[g] && !bus.ch_start[g]
                          && r_base_tick && (r_cnt == '0);

        // Config registers; only written while the channel is idle.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_period <= '0;
                r_mode   <= 1'b0;
            end else if (w_we) begin
                r_period <= bus.cfg_period;
                r_mode   <= bus.cfg_mode;
            end
        end

        // Channel IDLE/RUN state machine with its base_tick down-counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= w_expire;
                case (r_state)
                    S_IDLE: begin
                        if (bus.ch_start[g] && !bus.ch_stop[g] && (r_period != '0)) begin
                            r_state <= S_RUN;
                            r_cnt   <= r_period - PW'(1);
                        end
                    end
                    default: begin
                        if (bus.ch_stop[g]) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else if (bus.ch_start[g]) begin
                            r_cnt <= r_period - PW'(1);
                        end else if (w_expire) begin
                            if (r_mode) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_period - PW'(1);
                            end
                        end else if (r_base_tick) begin
                            r_cnt <= r_cnt - PW'(1);
                        end
                    end
                endcase
            end
        end

        // Sticky pending flag; a new expiry wins over a clear.
        always_ff @(posedge clk) begin
            if (rst)
                r_pend <= 1'b0;
            else if (w_expire)
                r_pend <= 1'b1;
            else if (bus.irq_clr[g])
                r_pend <= 1'b0;
        end

        assign w_tick[g]    = r_tick;
        assign w_busy[g]    = (r_state == S_RUN);
        assign w_pending[g] = r_pend;
    end

    assign bus.base_tick = r_base_tick;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.tick      = w_tick;
    assign bus.busy      = w_busy;
    assign bus.pending   = w_pending;
    assign bus.irq       = r_irq;
endmodule

// File: tb/tb_tick_scheduler.sv
// Randomized bench for tick_scheduler against a remaining-ticks reference model.
module tb_tick_scheduler;
    localparam int P  = 4;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_scheduler_if #(.PW(PW)) bus_if ();
    tick_scheduler #(.PRESCALE(P), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each running channel remembers how many counted
    // base_ticks remain before it fires.
    int unsigned n;
    bit          m_run [4];
    int          m_rem [4];
    int          m_per [4];
    bit          m_mode[4];
    bit [3:0]    e_tick, e_pend;
    bit          e_irq, e_err, e_bt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit [3:0] e_busy();
        bit [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = m_run[i];
        return b;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit [3:0] t;
        bit       err;
        int       ch;
        if (rst) begin
            n = 0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_rem[i] = 0; m_per[i] = 0; m_mode[i] = 0;
            end
            e_tick = 0; e_pend = 0; e_irq = 0; e_err = 0; e_bt = 0;
            return;
        end
        e_irq = |e_pend;
        ch    = int'(bus_if.cfg_ch);
        err   = bus_if.cfg_we && (m_run[ch] || bus_if.ch_start[ch]);
        t     = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_run[i]) begin
                if (bus_if.ch_stop[i]) m_run[i] = 0;
                else if (bus_if.ch_start[i]) m_rem[i] = m_per[i];
                else if (e_bt) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        t[i] = 1;
                        if (m_mode[i]) m_run[i] = 0;
                        else m_rem[i] = m_per[i];
                    end
                end
            end else if (bus_if.ch_start[i] && !bus_if.ch_stop[i] && m_per[i] != 0) begin
                m_run[i] = 1;
                m_rem[i] = m_per[i];
            end
        end
        if (bus_if.cfg_we && !err) begin
            m_per[ch]  = int'(bus_if.cfg_period);
            m_mode[ch] = bus_if.cfg_mode;
        end
        for (int i = 0; i < 4; i++)
            e_pend[i] = t[i] ? 1'b1 : (bus_if.irq_clr[i] ? 1'b0 : e_pend[i]);
        e_tick = t;
        e_err  = err;
        n++;
        e_bt = (n % P == 0);
    endtask

    task automatic compare_all();
        chk("base_tick", 32'(bus_if.base_tick), 32'(e_bt));
        chk("tick",      32'(bus_if.tick),      32'(e_tick));
        chk("busy",      32'(bus_if.busy),      32'(e_busy()));
        chk("pending",   32'(bus_if.pending),   32'(e_pend));
        chk("irq",       32'(bus_if.irq),       32'(e_irq));
        chk("cfg_err",   32'(bus_if.cfg_err),   32'(e_err));
    endtask

    task automatic clear_inputs();
        bus_if.cfg_we = 0; bus_if.cfg_ch = 0; bus_if.cfg_period = 0; bus_if.cfg_mode = 0;
        bus_if.ch_start = 0; bus_if.ch_stop = 0; bus_if.irq_clr = 0;
    endtask

    task automatic drive_random();
        int r;
        rst = ($urandom_range(0, 799) == 0);
        bus_if.cfg_we   = ($urandom_range(0, 5) == 0);
        bus_if.cfg_ch   = 2'($urandom_range(0, 3));
        bus_if.cfg_mode = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 15));
        if (r == 0)      bus_if.cfg_period = '0;
        else if (r == 1) bus_if.cfg_period = '1;
        else             bus_if.cfg_period = PW'($urandom_range(1, 6));
        for (int i = 0; i < 4; i++) begin
            bus_if.ch_start[i] = ($urandom_range(0, 19) == 0);
            bus_if.ch_stop[i]  = ($urandom_range(0, 39) == 0);
            bus_if.irq_clr[i]  = ($urandom_range(0, 9) == 0);
            // Aim strobes at the exact cycle a channel is about to expire.
            if (m_run[i] && e_bt && m_rem[i] == 1) begin
                r = int'($urandom_range(0, 5));
                if (r < 2)       bus_if.ch_stop[i]  = 1;
                else if (r < 4)  bus_if.irq_clr[i]  = 1;
                else if (r == 4) bus_if.ch_start[i] = 1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        for (int k = 0; k < 3; k++) cycle();
        rst = 0;
        // Quiet run: only the prescaler should be visible.
        for (int k = 0; k < 16; k++) cycle();
        // Directed: ch0 periodic period 3, ch1 one-shot period 2.
        bus_if.cfg_we = 1; bus_if.cfg_ch = 0; bus_if.cfg_period = 3; bus_if.cfg_mode = 0;
        cycle();
        bus_if.cfg_ch = 1; bus_if.cfg_period = 2; bus_if.cfg_mode = 1;
        cycle();
        bus_if.cfg_we = 0; bus_if.ch_start = 4'b0011;
        cycle();
        bus_if.ch_start = 0;
        for (int k = 0; k < 40; k++) cycle();
        // Rewrite a running channel (rejected), start with period 0 on ch3.
        bus_if.cfg_we = 1; bus_if.cfg_ch = 0; bus_if.cfg_period = 7; bus_if.ch_start[3] = 1;
        cycle();
        clear_inputs();
        bus_if.irq_clr = 4'b0010;
        cycle();
        bus_if.irq_clr = 0;
        for (int k = 0; k < 20; k++) cycle();
        // Mid-run reset.
        rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 4000; k++) begin
            drive_random();
            cycle();
        end
        rst = 0;
        clear_inputs();
        for (int k = 0; k < 50; k++) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
